// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundles the EX-stage multiply/divide issue signals, the
// MTHI/MTLO write path and the HI/LO/status results of mdu_ctrl.
//   master : pipeline side (drives issue + strobes, observes results)
//   slave  : mdu_ctrl side
interface mdu_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hilo_acc_ID;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        Stall_MDU;

   modport master (
      output start, op, a, b, hilo_acc_ID, wr_hi, wr_lo, wdata,
      input  hi, lo, busy, done, Stall_MDU
   );

   modport slave (
      input  start, op, a, b, hilo_acc_ID, wr_hi, wr_lo, wdata,
      output hi, lo, busy, done, Stall_MDU
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MIPS multiply/divide unit with HI/LO registers.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   m (slave)   : start/op/a/b issue, hilo_acc_ID, wr_hi/wr_lo/wdata,
//                 hi/lo results, busy, done, Stall_MDU
//   dbg_state   : current FSM state (IDLE=0, CALC=1, FIX=2)
//
// Handshake: `start` is a single-cycle request, accepted only when
// busy=0. Acceptance raises busy on the same edge; busy stays high for
// 33 more edges (32 CALC iterations + 1 FIX), and on the edge busy falls
// HI/LO are written and done pulses high for exactly one cycle. A start
// seen while busy=1 is dropped, never queued.
module mdu_ctrl (
   input  logic       clk,
   input  logic       rst,
   mdu_ctrl_if.slave  m,
   output logic [1:0] dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_hi_q, acc_hi_d;   // product upper half / partial remainder
   logic [31:0] acc_lo_q, acc_lo_d;   // multiplier->product lower / dividend->quotient
   logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
   logic        is_div_q, is_div_d;
   logic        neg_lo_q, neg_lo_d;   // negate LO (and full 64-bit product)
   logic        neg_hi_q, neg_hi_d;   // negate remainder
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        signed_op;
   logic        sign_diff;
   logic        op_div;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [32:0] div_trial;
   logic [63:0] prod;
   logic [63:0] prod_fix;

   assign signed_op = ~m.op[0];
   assign op_div    = m.op[1];
   assign sign_diff = signed_op & (m.a[31] ^ m.b[31]);

   // 32'h80000000 negates to itself, which read as unsigned is 2^31,
   // so a 32-bit unsigned magnitude covers the signed extreme.
   assign mag_a = (signed_op && m.a[31]) ? 32'd0 - m.a : m.a;
   assign mag_b = (signed_op && m.b[31]) ? 32'd0 - m.b : m.b;

   // Shift-add: add multiplicand to the upper half when the current
   // multiplier bit is set, then shift the 65-bit {carry, hi, lo} right.
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

   // Restoring division: bring the next dividend bit into the remainder
   // and keep the subtraction only when it does not go negative.
   assign div_sh    = {acc_hi_q, acc_lo_q[31]};
   assign div_trial = div_sh - {1'b0, opnd_q};

   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_lo_q ? 64'd0 - prod : prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (m.wr_hi) hi_d = m.wdata;
            if (m.wr_lo) lo_d = m.wdata;
            if (m.start) begin
               state_d  = CALC;
               busy_d   = 1'b1;
               cnt_d    = 6'd0;
               is_div_d = op_div;
               acc_hi_d = 32'd0;
               acc_lo_d = op_div ? mag_a : mag_b;
               opnd_d   = op_div ? mag_b : mag_a;
               // A zero divisor leaves the quotient as all ones; keeping it
               // un-negated yields LO = FFFFFFFF for the signed case too.
               neg_lo_d = sign_diff & ~(op_div & (m.b == 32'd0));
               // The remainder carries the dividend's sign, which also
               // returns HI = a for a zero divisor.
               neg_hi_d = op_div ? (signed_op & m.a[31]) : sign_diff;
            end
         end
         CALC: begin
            if (is_div_q) begin
               if (!div_trial[32]) begin
                  acc_hi_d = div_trial[31:0];
                  acc_lo_d = {acc_lo_q[30:0], 1'b1};
               end else begin
                  acc_hi_d = div_sh[31:0];
                  acc_lo_d = {acc_lo_q[30:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[32:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               lo_d = neg_lo_q ? 32'd0 - acc_lo_q : acc_lo_q;
               hi_d = neg_hi_q ? 32'd0 - acc_hi_q : acc_hi_q;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opnd_q   <= 32'd0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign m.hi        = hi_q;
   assign m.lo        = lo_q;
   assign m.busy      = busy_q;
   assign m.done      = done_q;
   // Stall the front end as soon as a HI/LO user sits in ID behind an
   // issuing or running operation, without waiting for busy to register.
   assign m.Stall_MDU = m.hilo_acc_ID & (busy_q | m.start);
   assign dbg_state   = state_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   mdu_ctrl_if bus();

   mdu_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .m         (bus),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [63:0] exp_q[$];          // {hi, lo} of accepted operations
   bit          m_busy = 0;
   bit          m_done = 0;
   int          m_left = 0;
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;

   function automatic logic [63:0] mdl_calc(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa, sb, sp, sq, sr;
      logic [63:0] up;
      logic [31:0] rh, rl;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = 32'd0;
      rl = 32'd0;
      case (op)
         2'b00: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
         2'b01: begin up = 64'(a) * 64'(b); rh = up[63:32]; rl = up[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin rh = a; rl = 32'hFFFFFFFF; end
            else begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
         end
         default: begin
            if (b == 32'd0) begin rh = a; rl = 32'hFFFFFFFF; end
            else begin rh = a % b; rl = a / b; end
         end
      endcase
      return {rh, rl};
   endfunction

   // Abstract timing: an accepted op holds busy for 33 edges, then publishes.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy = 0; m_done = 0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
            exp_q.delete();
         end else begin
            m_done = 0;
            if (m_busy) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_busy = 0;
                  m_done = 1;
                  if (exp_q.size() > 0) {m_hi, m_lo} = exp_q.pop_front();
               end
            end else begin
               if (bus.wr_hi) m_hi = bus.wdata;
               if (bus.wr_lo) m_lo = bus.wdata;
               if (bus.start) begin
                  exp_q.push_back(mdl_calc(bus.op, bus.a, bus.b));
                  m_busy = 1;
                  m_left = 33;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
            chk("cyc_done", 64'(bus.done), 64'(m_done));
            chk("cyc_hi",   64'(bus.hi),   64'(m_hi));
            chk("cyc_lo",   64'(bus.lo),   64'(m_lo));
            chk("cyc_stall", 64'(bus.Stall_MDU),
                64'(bus.hilo_acc_ID & (m_busy | bus.start)));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.start = 0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
      bus.hilo_acc_ID = 0; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 32'd0;
   endtask

   task automatic wait_done(output int lat, output int stall_cnt);
      lat = 0;
      stall_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.done) begin lat = i; break; end
         if (bus.Stall_MDU) stall_cnt++;
      end
      if (lat == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout actual=no_done required=done_within_40 t=%0t", $time);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #2;
      bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #2;
      bus.start = 0;
   endtask

   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
      int lat, sc;
      issue(op, a, b);
      wait_done(lat, sc);
      chk({name, "_lat"}, 64'(lat), 64'd34);
      chk({name, "_hi"},  64'(bus.hi), 64'(eh));
      chk({name, "_lo"},  64'(bus.lo), 64'(el));
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int lat, sc, done_seen;
      logic [63:0] r;
      rst = 1'b1;
      clear_inputs();
      bus.start = 1;
      bus.hilo_acc_ID = 1;
      repeat (2) @(negedge clk);
      chk("rst_hi",   64'(bus.hi), 64'd0);
      chk("rst_lo",   64'(bus.lo), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_stall_start", 64'(bus.Stall_MDU), 64'd1);
      bus.start = 0;
      #1;
      chk("rst_stall_nostart", 64'(bus.Stall_MDU), 64'd0);
      @(posedge clk); #2;
      bus.hilo_acc_ID = 0;
      rst = 1'b0;
      chk_en = 1;

      // pin the model to hand-computed values
      r = mdl_calc(2'b00, 32'hFFFFFFFD, 32'd5);
      chk("mdl_mult", r, 64'hFFFFFFFF_FFFFFFF1);
      r = mdl_calc(2'b11, 32'd100, 32'd7);
      chk("mdl_divu", r, {32'd2, 32'd14});
      r = mdl_calc(2'b10, 32'hFFFFFFF9, 32'd2);
      chk("mdl_div_neg", r, 64'hFFFFFFFF_FFFFFFFD);
      r = mdl_calc(2'b10, 32'h80000000, 32'hFFFFFFFF);
      chk("mdl_div_ext", r, {32'd0, 32'h80000000});
      r = mdl_calc(2'b10, 32'h12345678, 32'd0);
      chk("mdl_div0", r, {32'h12345678, 32'hFFFFFFFF});

      // directed operations with literal results
      run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      @(negedge clk);
      chk("mult_done_1cyc", 64'(bus.done), 64'd0);
      run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_ext", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      run_op("div0", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
      run_op("divu0_neg", 2'b11, 32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF);
      run_op("div0_neg", 2'b10, 32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF);
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);
      run_op("mult_ext", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0);

      // MTHI in idle, then the same strobe while busy
      @(posedge clk); #2;
      bus.wr_hi = 1; bus.wdata = 32'hCAFEF00D;
      @(posedge clk); #2;
      bus.wr_hi = 0;
      @(negedge clk);
      chk("mthi_idle", 64'(bus.hi), 64'hCAFEF00D);
      issue(2'b01, 32'd3, 32'd4);
      bus.wr_hi = 1; bus.wdata = 32'h12345678;
      @(posedge clk); #2;
      bus.wr_hi = 0;
      @(negedge clk);
      chk("mthi_busy", 64'(bus.hi), 64'hCAFEF00D);
      wait_done(lat, sc);
      chk("mthi_op_hi", 64'(bus.hi), 64'd0);
      chk("mthi_op_lo", 64'(bus.lo), 64'd12);

      // stall window and an ignored second start
      bus.hilo_acc_ID = 1;
      @(posedge clk); #2;
      bus.start = 1; bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd1000;
      @(posedge clk); #2;                 // edge N sampled start
      bus.start = 0; bus.a = 32'd9; bus.b = 32'd9;
      repeat (4) @(posedge clk);
      #2 bus.start = 1;                   // sampled at N+5
      @(posedge clk); #2;
      bus.start = 0;
      wait_done(lat, sc);
      chk("stall_lat", 64'(lat), 64'd29);
      chk("stall_cnt", 64'(sc), 64'd28);
      chk("stall_after", 64'(bus.Stall_MDU), 64'd0);
      chk("ign_start_lo", 64'(bus.lo), 64'd1000000);
      repeat (3) @(negedge clk);
      chk("ign_start_idle", 64'(bus.busy), 64'd0);
      bus.hilo_acc_ID = 0;

      // reset in the middle of a divide
      run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      issue(2'b10, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_busy", 64'(bus.busy), 64'd0);
      chk("mrst_hi",   64'(bus.hi), 64'd0);
      chk("mrst_lo",   64'(bus.lo), 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      chk("mrst_no_done", 64'(done_seen), 64'd0);
      run_op("mult_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);

      // randomized traffic, checked every cycle against the model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         bus.start       = ($urandom_range(0, 9) == 0);
         bus.op          = 2'($urandom_range(0, 3));
         bus.a           = rand_opnd();
         bus.b           = rand_opnd();
         bus.hilo_acc_ID = 1'($urandom_range(0, 1));
         bus.wr_hi       = ($urandom_range(0, 7) == 0);
         bus.wr_lo       = ($urandom_range(0, 7) == 0);
         bus.wdata       = $urandom;
         rst             = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk); #2;
      clear_inputs();
      rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
